// File: rtl/tape_cache_bram.sv
// Byte-wide single-clock cache for a downloaded tape image.
// The host download stream writes it, and the tape parser reads it through a registered port.
module tape_cache_bram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_AW    = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bram_download,
  input  logic                  bram_wr,
  input  logic [INIT_AW-1:0]    bram_init_address,
  input  logic [DATA_WIDTH-1:0] bram_din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  cs
);

  // Port protocol: there is no valid/ready handshake on either port. A write
  // is taken on every clk edge where bram_download and bram_wr are both high.
  // A read is taken on every edge where cs is high, and its data appears on
  // dout one cycle later. Both ports run independently, with no stall.

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  addr_in_range;
  logic                  wr_en;

  // Bytes beyond the array are dropped instead of wrapping, so an oversize
  // image cannot overwrite the start of the tape.
  assign addr_in_range = (bram_init_address >> ADDR_WIDTH) == '0;
  assign wr_en         = bram_download & bram_wr & addr_in_range & ~reset;

  // The storage has no reset, so a reset in mid-download keeps the bytes already written.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[bram_init_address[ADDR_WIDTH-1:0]] <= bram_din;
  end

  // Read-before-write: a read that collides with a write returns the old byte.
  always_ff @(posedge clk) begin
    if (reset)
      dout <= '0;
    else if (cs)
      dout <= mem[addr];
  end

endmodule

// File: tb/tb_tape_cache_bram.sv
// Directed and randomized bench for tape_cache_bram.
// It checks against an associative-array model of the cached tape image.
module tb_tape_cache_bram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bram_download = 1'b0;
  logic        bram_wr = 1'b0;
  logic [24:0] bram_init_address = '0;
  logic [7:0]  bram_din = '0;
  logic [15:0] addr = '0;
  logic [7:0]  dout;
  logic        cs = 1'b0;

  int tests_run = 0;
  int failed    = 0;

  // Only the bytes that have been written are known to the model.
  logic [7:0] ref_mem [int];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_known = 1'b0;

  tape_cache_bram dut (
    .clk               (clk),
    .reset             (reset),
    .bram_download     (bram_download),
    .bram_wr           (bram_wr),
    .bram_init_address (bram_init_address),
    .bram_din          (bram_din),
    .addr              (addr),
    .dout              (dout),
    .cs                (cs)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic rst_i, input logic dl, input logic wr,
                       input logic [24:0] wa, input logic [7:0] wd,
                       input logic rcs, input logic [15:0] ra, input string tag);
    reset             = rst_i;
    bram_download     = dl;
    bram_wr           = wr;
    bram_init_address = wa;
    bram_din          = wd;
    cs                = rcs;
    addr              = ra;
    if (rst_i) begin
      exp_dout  = 8'h00;
      exp_known = 1'b1;
    end else if (rcs) begin
      exp_known = ref_mem.exists(int'(ra));
      if (exp_known) exp_dout = ref_mem[int'(ra)];
    end
    // The model is updated after the read, so a read at the written address sees the old byte.
    if (!rst_i && dl && wr && int'(wa) < 65536)
      ref_mem[int'(wa)] = wd;
    @(posedge clk);
    @(negedge clk);
    if (exp_known) begin
      tests_run++;
      assert (dout === exp_dout) else begin
        failed++;
        $error("FAIL %s: dout=%h expected %h", tag, dout, exp_dout);
      end
    end
  endtask

  task automatic wr_byte(input logic [24:0] wa, input logic [7:0] wd, input string tag);
    cycle(1'b0, 1'b1, 1'b1, wa, wd, 1'b0, 16'h0000, tag);
  endtask

  task automatic rd_byte(input logic [15:0] ra, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, ra, tag);
  endtask

  logic [7:0] tape_hdr [8];

  initial begin
    tape_hdr[0] = 8'h16; tape_hdr[1] = 8'h16; tape_hdr[2] = 8'h16; tape_hdr[3] = 8'h24;
    tape_hdr[4] = 8'h00; tape_hdr[5] = 8'h00; tape_hdr[6] = 8'h80; tape_hdr[7] = 8'hC7;

    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, 16'h0000, "reset_init");

    // Reset clears dout, suppresses writes and keeps the memory contents.
    wr_byte(25'h5, 8'hAA, "prewrite5");
    wr_byte(25'h9, 8'h11, "prewrite9");
    rd_byte(16'h5, "pre_reset_rd5");
    cycle(1'b1, 1'b1, 1'b1, 25'h9, 8'h99, 1'b1, 16'h5, "reset_dout0");
    cycle(1'b1, 1'b0, 1'b0, 25'h0, 8'h00, 1'b1, 16'h5, "reset_dout1");
    rd_byte(16'h5, "reset_keeps_mem");
    rd_byte(16'h9, "reset_blocks_wr");

    // Download the header bytes, then read them back one address per cycle.
    for (int i = 0; i < 8; i++) wr_byte(25'(i), tape_hdr[i], "download");
    for (int i = 0; i < 8; i++) rd_byte(16'(i), "stream_read");

    // A write strobe outside a download is ignored, and so is an out-of-range address.
    cycle(1'b0, 1'b0, 1'b1, 25'h3, 8'hFF, 1'b0, 16'h0, "wr_no_dl");
    rd_byte(16'h3, "gate_no_download");
    wr_byte(25'h10003, 8'hFF, "wr_oversize");
    rd_byte(16'h3, "gate_no_wrap");
    wr_byte(25'h1FFFFFF, 8'hEE, "wr_oversize_max");
    rd_byte(16'hFFFF, "gate_max_addr");

    // With cs low, dout holds its last value.
    rd_byte(16'h6, "cs_read6");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, 25'h0, 8'h00, 1'b0, 16'h7, "cs_hold");
    rd_byte(16'h7, "cs_resume");

    // Read-before-write on a same-address collision.
    cycle(1'b0, 1'b1, 1'b1, 25'h2, 8'h5A, 1'b1, 16'h2, "collision_old");
    rd_byte(16'h2, "collision_new");

    // The top address works, and address 0 is not disturbed.
    wr_byte(25'hFFFF, 8'h3C, "wr_top");
    rd_byte(16'hFFFF, "top_read");
    rd_byte(16'h0, "top_no_alias");

    // Reset during a download keeps the bytes already written.
    wr_byte(25'h20, 8'h42, "dl_pre_reset");
    cycle(1'b1, 1'b1, 1'b0, 25'h21, 8'h00, 1'b0, 16'h0, "dl_reset");
    rd_byte(16'h20, "dl_reset_keep");

    // Random traffic in small windows at the bottom and top, to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [24:0] wa;
      logic [15:0] ra;
      case ($urandom_range(0, 9))
        0:       wa = {9'($urandom_range(1, 511)), 16'($urandom_range(0, 15))};
        1, 2:    wa = 25'(16'hFFF0 + 16'($urandom_range(0, 15)));
        default: wa = 25'($urandom_range(0, 15));
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                       : 16'($urandom_range(0, 15));
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), wa,
            8'($urandom), ($urandom_range(0, 3) != 0), ra, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
